// File: rtl/mult_acc_if.sv
// Product-in / result-out bundle for the mult_acc accumulator stage.
// master: upstream multiplier plus result consumer; slave: the accumulator.
interface mult_acc_if #(
  parameter int unsigned DIN_W = 16,
  parameter int unsigned ACC_W = 19,
  parameter int unsigned CNT_W = 3
);
  logic             din_valid;
  logic [DIN_W-1:0] din;
  logic             clr;
  logic [ACC_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  modport master (
    output din_valid, din, clr, dout_ready,
    input  dout, dout_valid, cnt, ovf
  );

  modport slave (
    input  din_valid, din, clr, dout_ready,
    output dout, dout_valid, cnt, ovf
  );
endinterface

// File: rtl/mult_acc.sv
// Sums each group of ACC_NUM valid products into one registered result with a
// valid/ready output; accumulation never stalls and overwritten results set ovf.
module mult_acc #(
  parameter int unsigned DIN_W   = 16,
  parameter int unsigned ACC_NUM = 8,
  parameter int unsigned ACC_W   = 19,
  parameter int unsigned CNT_W   = 3
) (
  input logic       clk,
  input logic       rst,
  mult_acc_if.slave bus
);

  typedef enum logic {
    FR_EMPTY,
    FR_ACC
  } frame_t;

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(ACC_NUM - 1);
  localparam bit               SINGLE = (ACC_NUM == 1);

  frame_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] dout_q;
  logic             dout_valid_q;
  logic             ovf_q;

  logic [DIN_W-1:0] din_w;
  logic [ACC_W-1:0] din_ext;
  logic             restart;
  logic [ACC_W-1:0] sum;
  logic             closing;
  logic             load;

  assign din_w   = bus.din;
  assign din_ext = ACC_W'(din_w);

  // clr makes the coincident sample the first of a fresh frame, so it shares
  // the EMPTY path: zero base, and a close only when a frame is one sample long.
  always_comb begin
    restart = 1'b0;
    sum     = '0;
    closing = 1'b0;
    load    = 1'b0;
    restart = bus.clr || (state == FR_EMPTY);
    sum     = (restart ? '0 : acc) + din_ext;
    closing = restart ? SINGLE : (cnt_q == LAST);
    load    = bus.din_valid && closing;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FR_EMPTY;
      acc          <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      if (bus.din_valid) begin
        if (closing) begin
          dout_q <= sum;
          acc    <= '0;
          cnt_q  <= '0;
          state  <= FR_EMPTY;
        end else begin
          acc   <= sum;
          cnt_q <= restart ? CNT_W'(1) : cnt_q + CNT_W'(1);
          state <= FR_ACC;
        end
      end else if (bus.clr) begin
        acc   <= '0;
        cnt_q <= '0;
        state <= FR_EMPTY;
      end

      if (load) begin
        dout_valid_q <= 1'b1;
      end else if (bus.dout_ready) begin
        dout_valid_q <= 1'b0;
      end

      if (bus.clr) begin
        ovf_q <= 1'b0;
      end else if (load && dout_valid_q && !bus.dout_ready) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.cnt        = cnt_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_mult_acc.sv
// Directed bench for mult_acc: three instances (ACC_NUM = 4, 8, 1) share the
// same input stimulus; each check targets the instance the scenario is about.
module tb_mult_acc;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic [15:0] din;
  logic        clr;
  logic        dout_ready;

  int unsigned n_total;
  int unsigned n_pass;

  mult_acc_if #(.DIN_W(16), .ACC_W(18), .CNT_W(2)) b4 ();
  mult_acc_if #(.DIN_W(16), .ACC_W(19), .CNT_W(3)) b8 ();
  mult_acc_if #(.DIN_W(16), .ACC_W(16), .CNT_W(1)) b1 ();

  assign b4.din_valid = din_valid;
  assign b4.din = din;
  assign b4.clr = clr;
  assign b4.dout_ready = dout_ready;
  assign b8.din_valid = din_valid;
  assign b8.din = din;
  assign b8.clr = clr;
  assign b8.dout_ready = dout_ready;
  assign b1.din_valid = din_valid;
  assign b1.din = din;
  assign b1.clr = clr;
  assign b1.dout_ready = dout_ready;

  mult_acc #(.DIN_W(16), .ACC_NUM(4), .ACC_W(18), .CNT_W(2)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  mult_acc #(.DIN_W(16), .ACC_NUM(8), .ACC_W(19), .CNT_W(3)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  mult_acc #(.DIN_W(16), .ACC_NUM(1), .ACC_W(16), .CNT_W(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [15:0] d;
    logic        c;
    logic        rdy;
    logic [17:0] e_dout;
    logic        e_dv;
    logic [1:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic dv, input logic [15:0] d, input logic c,
                              input logic rdy, input logic [17:0] e_dout,
                              input logic e_dv, input logic [1:0] e_cnt, input logic e_ovf);
    vec_t v;
    v.dv = dv; v.d = d; v.c = c; v.rdy = rdy;
    v.e_dout = e_dout; v.e_dv = e_dv; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dv, input logic [15:0] d, input logic c, input logic rdy);
    din_valid = dv; din = d; clr = c; dout_ready = rdy;
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] one_vals[3];
    n_total = 0;
    n_pass = 0;
    rst = 1'b1;
    din_valid = 1'b0; din = '0; clr = 1'b0; dout_ready = 1'b0;

    #12;
    chk("rst_u4_dout", 32'(b4.dout), 0);
    chk("rst_u4_dv", 32'(b4.dout_valid), 0);
    chk("rst_u4_cnt", 32'(b4.cnt), 0);
    chk("rst_u4_ovf", 32'(b4.ovf), 0);
    chk("rst_u8_dv", 32'(b8.dout_valid), 0);
    chk("rst_u1_dv", 32'(b1.dout_valid), 0);
    rst = 1'b0;

    // ACC_NUM = 4 table: dv, din, clr, rdy -> dout, dout_valid, cnt, ovf after the edge
    // basic sum
    add(1, 125, 0, 1,   0, 0, 1, 0);
    add(1, 160, 0, 1,   0, 0, 2, 0);
    add(1,  40, 0, 1,   0, 0, 3, 0);
    add(1, 105, 0, 1, 430, 1, 0, 0);
    add(0,   0, 0, 1, 430, 0, 0, 0);
    // gapped input
    add(1, 125, 0, 1, 430, 0, 1, 0);
    add(0,   0, 0, 1, 430, 0, 1, 0);
    add(0,   0, 0, 1, 430, 0, 1, 0);
    add(1, 160, 0, 1, 430, 0, 2, 0);
    add(0,   0, 0, 1, 430, 0, 2, 0);
    add(0,   0, 0, 1, 430, 0, 2, 0);
    add(1,  40, 0, 1, 430, 0, 3, 0);
    add(0,   0, 0, 1, 430, 0, 3, 0);
    add(0,   0, 0, 1, 430, 0, 3, 0);
    add(1, 105, 0, 1, 430, 1, 0, 0);
    add(0,   0, 0, 1, 430, 0, 0, 0);
    // backpressure and overflow
    add(1, 125, 0, 0, 430, 0, 1, 0);
    add(1, 160, 0, 0, 430, 0, 2, 0);
    add(1,  40, 0, 0, 430, 0, 3, 0);
    add(1, 105, 0, 0, 430, 1, 0, 0);
    add(1, 112, 0, 0, 430, 1, 1, 0);
    add(1, 119, 0, 0, 430, 1, 2, 0);
    add(1, 126, 0, 0, 430, 1, 3, 0);
    add(1, 133, 0, 0, 490, 1, 0, 1);
    add(0,   0, 0, 0, 490, 1, 0, 1);
    add(0,   0, 0, 1, 490, 0, 0, 1);
    add(0,   0, 0, 0, 490, 0, 0, 1);
    // clr alone clears ovf, leaves dout
    add(0,   0, 1, 0, 490, 0, 0, 0);
    // coincident load and handshake
    add(1,   1, 0, 0, 490, 0, 1, 0);
    add(1,   2, 0, 0, 490, 0, 2, 0);
    add(1,   3, 0, 0, 490, 0, 3, 0);
    add(1,   4, 0, 0,  10, 1, 0, 0);
    add(1,   5, 0, 0,  10, 1, 1, 0);
    add(1,   6, 0, 0,  10, 1, 2, 0);
    add(1,   7, 0, 0,  10, 1, 3, 0);
    add(1,   8, 0, 1,  26, 1, 0, 0);
    add(0,   0, 0, 0,  26, 1, 0, 0);
    add(0,   0, 0, 1,  26, 0, 0, 0);
    // clr mid-frame with coincident sample
    add(1, 125, 0, 1,  26, 0, 1, 0);
    add(1, 160, 0, 1,  26, 0, 2, 0);
    add(1,  40, 1, 1,  26, 0, 1, 0);
    add(1, 105, 0, 1,  26, 0, 2, 0);
    add(1,   3, 0, 1,  26, 0, 3, 0);
    add(1,   9, 0, 1, 157, 1, 0, 0);
    add(0,   0, 0, 1, 157, 0, 0, 0);

    tick();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].dv, vecs[i].d, vecs[i].c, vecs[i].rdy);
      chk($sformatf("v%0d_dout", i), 32'(b4.dout), 32'(vecs[i].e_dout));
      chk($sformatf("v%0d_dv", i), 32'(b4.dout_valid), 32'(vecs[i].e_dv));
      chk($sformatf("v%0d_cnt", i), 32'(b4.cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_ovf", i), 32'(b4.ovf), 32'(vecs[i].e_ovf));
    end

    // ACC_NUM = 8 full-scale sum, no wrap
    pulse_rst();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'hFFFF, 1'b0, 1'b1);
      chk($sformatf("max_cnt%0d", i), 32'(b8.cnt), 32'((i + 1) % 8));
      chk($sformatf("max_dv%0d", i), 32'(b8.dout_valid), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("max_dout", 32'(b8.dout), 32'h7FFF8);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("max_dv_drop", 32'(b8.dout_valid), 0);

    // ACC_NUM = 1: every sample is a closing sample
    pulse_rst();
    one_vals[0] = 16'd7;
    one_vals[1] = 16'hFFFF;
    one_vals[2] = 16'd300;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, one_vals[i], 1'b0, 1'b1);
      chk($sformatf("one_dout%0d", i), 32'(b1.dout), 32'(one_vals[i]));
      chk($sformatf("one_dv%0d", i), 32'(b1.dout_valid), 1);
      chk($sformatf("one_cnt%0d", i), 32'(b1.cnt), 0);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("one_dv_drop", 32'(b1.dout_valid), 0);
    drive(1'b1, 16'd55, 1'b1, 1'b1);
    chk("one_clr_dout", 32'(b1.dout), 55);
    chk("one_clr_dv", 32'(b1.dout_valid), 1);

    // rst mid-frame with a pending result: outputs clear before any clock edge
    pulse_rst();
    drive(1'b1, 16'd1, 1'b0, 1'b0);
    drive(1'b1, 16'd2, 1'b0, 1'b0);
    drive(1'b1, 16'd3, 1'b0, 1'b0);
    drive(1'b1, 16'd4, 1'b0, 1'b0);
    chk("pre_rst_dout", 32'(b4.dout), 10);
    drive(1'b1, 16'd10, 1'b0, 1'b0);
    drive(1'b1, 16'd20, 1'b0, 1'b0);
    chk("pre_rst_cnt", 32'(b4.cnt), 2);
    din_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_dout", 32'(b4.dout), 0);
    chk("async_rst_dv", 32'(b4.dout_valid), 0);
    chk("async_rst_cnt", 32'(b4.cnt), 0);
    chk("async_rst_ovf", 32'(b4.ovf), 0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd5, 1'b0, 1'b1);
    chk("post_rst_dout", 32'(b4.dout), 20);
    chk("post_rst_dv", 32'(b4.dout_valid), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_acc.md
# mult_acc

Accumulator stage placed directly downstream of `mult_line`. It sums each group of `ACC_NUM` consecutive valid products into one result, forming a dot product or block sum. The result is held in an output register with a valid/ready handshake. `mult_line` has no backpressure, so accumulation never stalls; a result that is not consumed in time is overwritten and flagged.

## Interface
- `DIN_W`, default 16: product width; equals `MULTLEN_1 + MULTLEN_2` of the upstream multiplier.
- `ACC_NUM`, default 8: products per result; legal range is 1 or more.
- `ACC_W`, default 19: accumulator and result width; equals `DIN_W + clog2(ACC_NUM)` for overflow-free sums.
- `CNT_W`, default 3: width of the sample counter; equals `max(1, clog2(ACC_NUM))`.
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `din_valid`, in, 1: product valid; connects to `mult_line.valid`.
- `din`, in, `DIN_W`: unsigned product; connects to `mult_line.dout`.
- `clr`, in, 1: synchronous frame restart.
- `dout`, out, `ACC_W`: completed sum.
- `dout_valid`, out, 1: `dout` holds an unconsumed result.
- `dout_ready`, in, 1: consumer accepts `dout`.
- `cnt`, out, `CNT_W`: number of products accumulated in the current frame.
- `ovf`, out, 1: sticky flag; a result was lost.

## Operation
- Internal state: accumulator `acc` (`ACC_W` bits), counter `cnt`, output register `dout`/`dout_valid`, flag `ovf`.
- Frame FSM:
  - EMPTY (`cnt == 0`): on `din_valid`, go to ACC with `acc <= din`, `cnt <= 1`.
  - ACC: on `din_valid` with `cnt < ACC_NUM-1`, `acc <= acc + din`, `cnt++`.
  - Closing sample: on `din_valid` with `cnt == ACC_NUM-1`, `dout <= acc + din`, `dout_valid <= 1`, `acc <= 0`, `cnt <= 0`, return to EMPTY.
  - With `ACC_NUM = 1`, every valid sample is a closing sample: `dout <= din`.
- Output register states:
  - EMPTY: `dout_valid = 0`.
  - FULL: `dout_valid = 1`. A handshake (`dout_valid && dout_ready`) returns it to EMPTY.
  - `dout` stays stable while FULL unless a new result loads.
- Arithmetic:
  - Unsigned; `din` is zero-extended to `ACC_W`.
  - If `ACC_W` is below the rule, sums wrap modulo `2^ACC_W` with no flag.
- `clr`:
  - Sets `acc <= 0`, `cnt <= 0`, `ovf <= 0`; the output register is untouched.
  - `clr` and `din_valid` in the same cycle: `clr` wins, and `din` becomes sample 1 of the new frame (`acc <= din`, `cnt <= 1`). With `ACC_NUM = 1` it closes immediately.
- Simultaneous events:
  - Load and handshake in the same cycle: the new result loads, `dout_valid` stays 1, `ovf` is unchanged.
  - Load while FULL and no handshake: the new result overwrites `dout`, `dout_valid` stays 1, `ovf <= 1`.
  - `ovf` clears only on `rst` or `clr`.
- `din_valid = 0`: `din` is ignored and all frame state holds.

## Timing
- Reset (asynchronous, takes effect immediately): `dout = 0`, `dout_valid = 0`, `cnt = 0`, `ovf = 0`, `acc = 0`. `rst` asserted mid-frame discards the partial sum and any pending result.
- Latency: `dout`/`dout_valid` update on the clock edge that samples the closing `din_valid`, so they are visible in the following cycle. No combinational path from `din` to `dout`.
- Throughput: one product per cycle, sustained indefinitely; `din_valid` is never stalled.
- `cnt` updates on the same edge as `acc`.
- `dout_ready` is sampled only when `dout_valid = 1`. `dout_valid` falls on the edge after the handshake unless a load coincides.
- The consumer must accept within `ACC_NUM` cycles of `dout_valid` rising under back-to-back input, or `ovf` is set.

## Test plan
- Basic sum: `ACC_NUM = 4`, products 125, 160, 40, 105 on consecutive cycles, `dout_ready = 1` -> `dout = 430` with a one-cycle `dout_valid` pulse one cycle after the 105 sample; `cnt` steps 1, 2, 3, 0.
- Gapped input: the same four products with 2-cycle gaps of `din_valid = 0` -> `dout = 430`; `cnt` holds during the gaps.
- Backpressure and overflow: `dout_ready = 0`, two full frames (sums 430, then 7*16..7*19 = 490) -> `dout = 490`, `dout_valid = 1`, `ovf = 1`. Then `dout_ready = 1` for one cycle -> `dout_valid = 0`, `ovf` stays 1.
- Coincident load and handshake: `dout_ready` pulses on the exact edge a new frame closes -> `dout_valid` stays 1 with the new sum; `ovf = 0`.
- `clr` mid-frame: after 2 samples (125, 160), assert `clr` with `din_valid` and `din = 40`, then send 105, 3, 9 -> `dout = 157`, `ovf = 0`.
- Boundaries:
  - Max values: `ACC_NUM = 8`, `din = 0xFFFF` x8 -> `dout = 0x7FFF8` (no wrap).
  - `ACC_NUM = 1`: every valid sample appears on `dout` after 1 cycle.
  - `rst` pulse mid-frame: outputs 0 immediately, and the next frame sums from zero.
